// File: rtl/axil_req_arbiter.sv
// Two-requester round-robin arbiter in front of a single AXI-Lite master port.
// Optional AXIL_ARB_TIMEOUT_EN adds a 16-cycle per-phase watchdog that completes with resp=4.
//
// state     | meaning
// S_IDLE    | waiting for a request; arbitrate and latch payload
// S_WR_REQ  | awvalid/wvalid outstanding, each drops on its own handshake
// S_WR_RESP | bready high, waiting for bvalid
// S_RD_REQ  | arvalid outstanding
// S_RD_RESP | rready high, waiting for rvalid
// S_DONE    | one-cycle done pulse to the granted requester
module axil_req_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RESP_WIDTH = 3
) (
  input  logic                    axi_aclk,
  input  logic                    axi_areset,
  input  logic                    r0_req,
  input  logic                    r0_we,
  input  logic [ADDR_WIDTH-1:0]   r0_addr,
  input  logic [DATA_WIDTH-1:0]   r0_wdata,
  input  logic [DATA_WIDTH/8-1:0] r0_wstrb,
  output logic                    r0_done,
  output logic [DATA_WIDTH-1:0]   r0_rdata,
  output logic [RESP_WIDTH-1:0]   r0_resp,
  input  logic                    r1_req,
  input  logic                    r1_we,
  input  logic [ADDR_WIDTH-1:0]   r1_addr,
  input  logic [DATA_WIDTH-1:0]   r1_wdata,
  input  logic [DATA_WIDTH/8-1:0] r1_wstrb,
  output logic                    r1_done,
  output logic [DATA_WIDTH-1:0]   r1_rdata,
  output logic [RESP_WIDTH-1:0]   r1_resp,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [RESP_WIDTH-1:0]   m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [RESP_WIDTH-1:0]   m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam logic [RESP_WIDTH-1:0] RESP_TIMEOUT = RESP_WIDTH'(4);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_RESP, S_DONE
  } state_t;

  state_t                  state, state_nxt;
  logic                    grant, grant_nxt;
  logic                    last_gnt, last_gnt_nxt;
  logic                    we_sel;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_nxt;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_nxt;
  logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_nxt;
  logic                    awvalid_q, awvalid_nxt, wvalid_q, wvalid_nxt;
  logic                    bready_q, bready_nxt, arvalid_q, arvalid_nxt;
  logic                    rready_q, rready_nxt;
  logic [1:0]              done_q, done_nxt;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_nxt;
  logic [RESP_WIDTH-1:0]   resp_q, resp_nxt;
  logic                    tmo_hit;

`ifdef AXIL_ARB_TIMEOUT_EN
  localparam logic [3:0] TMO_LOAD = 4'd15;
  logic [3:0] tmo_cnt, tmo_cnt_nxt;

  assign tmo_hit = (state inside {S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_RESP}) && (tmo_cnt == 4'd0);

  always_comb begin
    tmo_cnt_nxt = tmo_cnt;
    if (state_nxt != state)    tmo_cnt_nxt = TMO_LOAD;
    else if (tmo_cnt != 4'd0)  tmo_cnt_nxt = tmo_cnt - 4'd1;
  end

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) tmo_cnt <= TMO_LOAD;
    else            tmo_cnt <= tmo_cnt_nxt;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant;
    last_gnt_nxt = last_gnt;
    we_sel       = 1'b0;
    addr_nxt     = addr_q;
    wdata_nxt    = wdata_q;
    wstrb_nxt    = wstrb_q;
    awvalid_nxt  = awvalid_q;
    wvalid_nxt   = wvalid_q;
    bready_nxt   = bready_q;
    arvalid_nxt  = arvalid_q;
    rready_nxt   = rready_q;
    done_nxt     = 2'b00;
    rdata_nxt    = rdata_q;
    resp_nxt     = resp_q;
    case (state)
      S_IDLE: begin
        if (r0_req || r1_req) begin
          // last_gnt=1 means r1 was served last, so r0 wins a tie
          grant_nxt    = (r0_req && r1_req) ? ~last_gnt : r1_req;
          last_gnt_nxt = grant_nxt;
          we_sel       = grant_nxt ? r1_we : r0_we;
          addr_nxt     = grant_nxt ? r1_addr : r0_addr;
          wdata_nxt    = grant_nxt ? r1_wdata : r0_wdata;
          wstrb_nxt    = grant_nxt ? r1_wstrb : r0_wstrb;
          if (we_sel) begin
            state_nxt   = S_WR_REQ;
            awvalid_nxt = 1'b1;
            wvalid_nxt  = 1'b1;
          end else begin
            state_nxt   = S_RD_REQ;
            arvalid_nxt = 1'b1;
          end
        end
      end
      S_WR_REQ: begin
        awvalid_nxt = awvalid_q && !m_axi_awready;
        wvalid_nxt  = wvalid_q && !m_axi_wready;
        if (!awvalid_nxt && !wvalid_nxt) begin
          state_nxt  = S_WR_RESP;
          bready_nxt = 1'b1;
        end
      end
      S_WR_RESP: begin
        if (m_axi_bvalid) begin
          bready_nxt = 1'b0;
          resp_nxt   = m_axi_bresp;
          rdata_nxt  = '0;
          done_nxt   = grant ? 2'b10 : 2'b01;
          state_nxt  = S_DONE;
        end
      end
      S_RD_REQ: begin
        if (m_axi_arready) begin
          arvalid_nxt = 1'b0;
          rready_nxt  = 1'b1;
          state_nxt   = S_RD_RESP;
        end
      end
      S_RD_RESP: begin
        if (m_axi_rvalid) begin
          rready_nxt = 1'b0;
          resp_nxt   = m_axi_rresp;
          rdata_nxt  = m_axi_rdata;
          done_nxt   = grant ? 2'b10 : 2'b01;
          state_nxt  = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    // a phase that makes progress on its final cycle completes normally
    if (tmo_hit && (state_nxt == state)) begin
      awvalid_nxt = 1'b0;
      wvalid_nxt  = 1'b0;
      bready_nxt  = 1'b0;
      arvalid_nxt = 1'b0;
      rready_nxt  = 1'b0;
      rdata_nxt   = '0;
      resp_nxt    = RESP_TIMEOUT;
      done_nxt    = grant ? 2'b10 : 2'b01;
      state_nxt   = S_DONE;
    end
  end

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      state     <= S_IDLE;
      grant     <= 1'b0;
      last_gnt  <= 1'b1;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      done_q    <= 2'b00;
      rdata_q   <= '0;
      resp_q    <= '0;
    end else begin
      state     <= state_nxt;
      grant     <= grant_nxt;
      last_gnt  <= last_gnt_nxt;
      addr_q    <= addr_nxt;
      wdata_q   <= wdata_nxt;
      wstrb_q   <= wstrb_nxt;
      awvalid_q <= awvalid_nxt;
      wvalid_q  <= wvalid_nxt;
      bready_q  <= bready_nxt;
      arvalid_q <= arvalid_nxt;
      rready_q  <= rready_nxt;
      done_q    <= done_nxt;
      rdata_q   <= rdata_nxt;
      resp_q    <= resp_nxt;
    end
  end

  assign m_axi_awaddr  = addr_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;
  assign r0_done       = done_q[0];
  assign r1_done       = done_q[1];
  assign r0_rdata      = rdata_q;
  assign r1_rdata      = rdata_q;
  assign r0_resp       = resp_q;
  assign r1_resp       = resp_q;

endmodule

// File: tb/tb_axil_req_arbiter.sv
// Bench for axil_req_arbiter: behavioural AXI-Lite slave with programmable delays,
// scoreboard of expected completions checked on each done pulse.
module tb_axil_req_arbiter;

  logic        axi_aclk = 1'b0;
  logic        axi_areset;
  logic        r0_req, r0_we, r1_req, r1_we;
  logic [7:0]  r0_addr, r1_addr;
  logic [31:0] r0_wdata, r1_wdata;
  logic [3:0]  r0_wstrb, r1_wstrb;
  logic        r0_done, r1_done;
  logic [31:0] r0_rdata, r1_rdata;
  logic [2:0]  r0_resp, r1_resp;
  logic [7:0]  m_axi_awaddr, m_axi_araddr;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [31:0] m_axi_wdata, m_axi_rdata;
  logic [3:0]  m_axi_wstrb;
  logic [2:0]  m_axi_bresp, m_axi_rresp;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready;

  axil_req_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .RESP_WIDTH(3)) dut (
    .axi_aclk(axi_aclk), .axi_areset(axi_areset),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_wstrb(r0_wstrb),
    .r0_done(r0_done), .r0_rdata(r0_rdata), .r0_resp(r0_resp),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_wstrb(r1_wstrb),
    .r1_done(r1_done), .r1_rdata(r1_rdata), .r1_resp(r1_resp),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  always #5 axi_aclk = ~axi_aclk;

  int n_vec = 0;
  int n_miscmp = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    bit          id;
    bit          we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic [2:0]  resp;
    bit          chk_addr;
  } exp_t;
  exp_t sb[$];

  function automatic void push(input bit id, input bit we, input logic [7:0] a,
                               input logic [31:0] wd, input logic [3:0] ws,
                               input logic [31:0] rd, input logic [2:0] rs, input bit ca);
    exp_t e;
    e.id = id; e.we = we; e.addr = a; e.wdata = wd; e.wstrb = ws;
    e.rdata = rd; e.resp = rs; e.chk_addr = ca;
    sb.push_back(e);
  endfunction

  function automatic logic [31:0] rd_of(input logic [7:0] a);
    return {24'hC0FFEE, a};
  endfunction

  // slave model: readies/valids change on the falling edge
  int s_aw_dly, s_w_dly, s_b_dly, s_ar_dly, s_r_dly;
  logic [2:0] s_bresp, s_rresp;
  int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  bit aw_hs, w_hs, ar_hs, b_pend, r_pend;
  logic [7:0]  cap_addr;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_wstrb;

  assign m_axi_bresp = s_bresp;
  assign m_axi_rresp = s_rresp;

  always @(negedge axi_aclk) begin
    if (axi_areset) begin
      m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
      m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
      aw_hs = 0; w_hs = 0; ar_hs = 0; b_pend = 0; r_pend = 0;
      cap_addr = '0; cap_wdata = '0; cap_wstrb = '0;
    end else begin
      if (b_pend) begin
        m_axi_bvalid = 1'b0; aw_hs = 0; w_hs = 0; b_cnt = 0; b_pend = 0;
      end else if (aw_hs && w_hs && !m_axi_bvalid) begin
        if (b_cnt >= s_b_dly) m_axi_bvalid = 1'b1;
        else b_cnt++;
      end
      m_axi_awready = m_axi_awvalid && !aw_hs && (aw_cnt >= s_aw_dly);
      if (m_axi_awready) begin aw_hs = 1; aw_cnt = 0; cap_addr = m_axi_awaddr; end
      else if (m_axi_awvalid) aw_cnt++;
      m_axi_wready = m_axi_wvalid && !w_hs && (w_cnt >= s_w_dly);
      if (m_axi_wready) begin w_hs = 1; w_cnt = 0; cap_wdata = m_axi_wdata; cap_wstrb = m_axi_wstrb; end
      else if (m_axi_wvalid) w_cnt++;
      b_pend = m_axi_bvalid && m_axi_bready;

      if (r_pend) begin
        m_axi_rvalid = 1'b0; ar_hs = 0; r_cnt = 0; r_pend = 0;
      end else if (ar_hs && !m_axi_rvalid) begin
        if (r_cnt >= s_r_dly) begin m_axi_rvalid = 1'b1; m_axi_rdata = rd_of(cap_addr); end
        else r_cnt++;
      end
      m_axi_arready = m_axi_arvalid && !ar_hs && (ar_cnt >= s_ar_dly);
      if (m_axi_arready) begin ar_hs = 1; ar_cnt = 0; cap_addr = m_axi_araddr; end
      else if (m_axi_arvalid) ar_cnt++;
      r_pend = m_axi_rvalid && m_axi_rready;
    end
  end

  // pending-handshake flags sampled on the rising edge, checked on the next falling edge
  bit p_aw, p_w, p_ar;
  always @(posedge axi_aclk) begin
    p_aw = !axi_areset && m_axi_awvalid && !m_axi_awready;
    p_w  = !axi_areset && m_axi_wvalid && !m_axi_wready;
    p_ar = !axi_areset && m_axi_arvalid && !m_axi_arready;
  end

  always @(negedge axi_aclk) begin
    exp_t e;
    if (!axi_areset) begin
      if (p_aw) check_val("aw_hold", m_axi_awvalid, 1'b1);
      if (p_w)  check_val("w_hold", m_axi_wvalid, 1'b1);
      if (p_ar) check_val("ar_hold", m_axi_arvalid, 1'b1);
      if (m_axi_arvalid) check_val("rd_excl", {m_axi_awvalid, m_axi_wvalid}, 2'b00);
      if (m_axi_awvalid || m_axi_wvalid) check_val("wr_excl", m_axi_arvalid, 1'b0);
      if (r0_done || r1_done) begin
        if (sb.size() == 0) check_val("sb_spurious", {r1_done, r0_done}, 2'b00);
        else begin
          e = sb.pop_front();
          check_val("done_sel", {r1_done, r0_done}, e.id ? 2'b10 : 2'b01);
          check_val("rdata", e.id ? r1_rdata : r0_rdata, e.rdata);
          check_val("resp", e.id ? r1_resp : r0_resp, e.resp);
          if (e.chk_addr) begin
            check_val("addr", cap_addr, e.addr);
            if (e.we) begin
              check_val("wdata", cap_wdata, e.wdata);
              check_val("wstrb", cap_wstrb, e.wstrb);
            end
          end
        end
      end
    end
  end

  // called on a falling edge; returns falling edges elapsed until done
  task automatic do_txn(input bit id, input bit we, input logic [7:0] a, input logic [31:0] wd,
                        input logic [3:0] ws, input bit keep, output int lat);
    bit got;
    if (!id) begin r0_we = we; r0_addr = a; r0_wdata = wd; r0_wstrb = ws; r0_req = 1'b1; end
    else     begin r1_we = we; r1_addr = a; r1_wdata = wd; r1_wstrb = ws; r1_req = 1'b1; end
    lat = 0;
    got = 0;
    while (!got && lat < 64) begin
      @(negedge axi_aclk);
      lat++;
      if ((!id && r0_done) || (id && r1_done)) got = 1;
    end
    check_val("txn_complete", got, 1'b1);
    if (!keep) begin
      if (!id) r0_req = 1'b0;
      else     r1_req = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int lat0, lat0b, lat1;

  initial begin
    axi_areset = 1'b1;
    r0_req = 0; r0_we = 0; r0_addr = '0; r0_wdata = '0; r0_wstrb = '0;
    r1_req = 0; r1_we = 0; r1_addr = '0; r1_wdata = '0; r1_wstrb = '0;
    s_aw_dly = 0; s_w_dly = 0; s_b_dly = 0; s_ar_dly = 0; s_r_dly = 0;
    s_bresp = 3'd0; s_rresp = 3'd0;
    repeat (3) @(negedge axi_aclk);
    check_val("rst_ctl", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready,
                          r0_done, r1_done, r0_resp, r1_resp}, '0);
    check_val("rst_rdata", {r0_rdata, r1_rdata}, '0);
    axi_areset = 1'b0;
    @(negedge axi_aclk);

    // zero-wait write from r0
    push(0, 1, 8'h00, 32'd25, 4'hF, 32'd0, 3'd0, 1);
    fork
      do_txn(0, 1, 8'h00, 32'd25, 4'hF, 0, lat0);
      begin
        @(negedge axi_aclk);
        check_val("aw_w_next", {m_axi_awvalid, m_axi_wvalid}, 2'b11);
      end
    join
    check_val("wr_lat", lat0, 3);
    @(negedge axi_aclk);

    // r1 write with DECERR, then r1 read with SLVERR
    s_bresp = 3'd3;
    push(1, 1, 8'h04, 32'h1234_5678, 4'h5, 32'd0, 3'd3, 1);
    do_txn(1, 1, 8'h04, 32'h1234_5678, 4'h5, 0, lat1);
    check_val("r1_wr_lat", lat1, 3);
    @(negedge axi_aclk);
    s_rresp = 3'd2;
    push(1, 0, 8'h30, 32'd0, 4'h0, rd_of(8'h30), 3'd2, 1);
    do_txn(1, 0, 8'h30, 32'd0, 4'h0, 0, lat1);
    check_val("r1_rd_lat", lat1, 3);
    @(negedge axi_aclk);
    s_bresp = 3'd0; s_rresp = 3'd0;

    // simultaneous reads: r0 first, r1 back-to-back
    push(0, 0, 8'h08, 32'd0, 4'h0, rd_of(8'h08), 3'd0, 1);
    push(1, 0, 8'h0C, 32'd0, 4'h0, rd_of(8'h0C), 3'd0, 1);
    fork
      do_txn(0, 0, 8'h08, 32'd0, 4'h0, 0, lat0);
      do_txn(1, 0, 8'h0C, 32'd0, 4'h0, 0, lat1);
    join
    check_val("rr_r0_lat", lat0, 3);
    check_val("rr_r1_lat", lat1, 7);
    @(negedge axi_aclk);

    // r0 re-requests with r1 pending: r1 goes before r0's second transaction
    push(0, 0, 8'h08, 32'd0, 4'h0, rd_of(8'h08), 3'd0, 1);
    push(1, 0, 8'h0C, 32'd0, 4'h0, rd_of(8'h0C), 3'd0, 1);
    push(0, 1, 8'h10, 32'hDEAD_BEEF, 4'h3, 32'd0, 3'd0, 1);
    fork
      begin
        do_txn(0, 0, 8'h08, 32'd0, 4'h0, 1, lat0);
        do_txn(0, 1, 8'h10, 32'hDEAD_BEEF, 4'h3, 0, lat0b);
      end
      do_txn(1, 0, 8'h0C, 32'd0, 4'h0, 0, lat1);
    join
    check_val("rr2_r0a_lat", lat0, 3);
    check_val("rr2_r1_lat", lat1, 7);
    check_val("rr2_r0b_lat", lat0b, 8);
    @(negedge axi_aclk);

    // awready two cycles ahead of wready, bvalid held off five cycles
    s_w_dly = 2; s_b_dly = 5; s_bresp = 3'd2;
    push(0, 1, 8'h40, 32'hA5A5_5A5A, 4'hC, 32'd0, 3'd2, 1);
    fork
      do_txn(0, 1, 8'h40, 32'hA5A5_5A5A, 4'hC, 0, lat0);
      begin
        @(negedge axi_aclk);
        check_val("split_c1", {m_axi_awvalid, m_axi_wvalid}, 2'b11);
        @(negedge axi_aclk);
        check_val("split_c2", {m_axi_awvalid, m_axi_wvalid}, 2'b01);
        @(negedge axi_aclk);
        check_val("split_c3", {m_axi_awvalid, m_axi_wvalid}, 2'b01);
      end
    join
    check_val("split_lat", lat0, 10);
    @(negedge axi_aclk);
    s_w_dly = 0; s_b_dly = 0; s_bresp = 3'd0;

    // reset in RD_RESP abandons the read; pointer returns to r0
    s_r_dly = 10;
    r0_we = 1'b0; r0_addr = 8'h20; r0_req = 1'b1;
    repeat (2) @(negedge axi_aclk);
    check_val("in_rd_resp", {m_axi_rready, m_axi_arvalid}, 2'b10);
    axi_areset = 1'b1;
    r0_req = 1'b0;
    #1;
    check_val("mid_rst_ctl", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready,
                              r0_done, r1_done, r0_resp, r1_resp}, '0);
    check_val("mid_rst_rdata", {r0_rdata, r1_rdata}, '0);
    repeat (2) @(negedge axi_aclk);
    axi_areset = 1'b0;
    s_r_dly = 0;
    @(negedge axi_aclk);
    push(0, 0, 8'h24, 32'd0, 4'h0, rd_of(8'h24), 3'd0, 1);
    push(1, 0, 8'h28, 32'd0, 4'h0, rd_of(8'h28), 3'd0, 1);
    fork
      do_txn(0, 0, 8'h24, 32'd0, 4'h0, 0, lat0);
      do_txn(1, 0, 8'h28, 32'd0, 4'h0, 0, lat1);
    join
    check_val("post_rst_r0_lat", lat0, 3);
    check_val("post_rst_r1_lat", lat1, 7);
    @(negedge axi_aclk);

    // slave never accepts the read address
    s_ar_dly = 1000;
`ifdef AXIL_ARB_TIMEOUT_EN
    push(0, 0, 8'h50, 32'd0, 4'h0, 32'd0, 3'd4, 0);
    do_txn(0, 0, 8'h50, 32'd0, 4'h0, 0, lat0);
    check_val("tmo_lat", lat0, 17);
    @(negedge axi_aclk);
    check_val("tmo_arvalid_low", m_axi_arvalid, 1'b0);
    s_ar_dly = 0;
`else
    r0_we = 1'b0; r0_addr = 8'h50; r0_req = 1'b1;
    repeat (40) @(negedge axi_aclk);
    check_val("no_tmo_arvalid", m_axi_arvalid, 1'b1);
    check_val("no_tmo_done", r0_done, 1'b0);
    axi_areset = 1'b1;
    r0_req = 1'b0;
    repeat (2) @(negedge axi_aclk);
    axi_areset = 1'b0;
    s_ar_dly = 0;
    @(negedge axi_aclk);
`endif

    push(1, 0, 8'h54, 32'd0, 4'h0, rd_of(8'h54), 3'd0, 1);
    do_txn(1, 0, 8'h54, 32'd0, 4'h0, 0, lat1);
    check_val("final_rd_lat", lat1, 3);
    repeat (3) @(negedge axi_aclk);
    check_val("sb_left", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
